mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM stage: turns EX-stage loads/stores into a req/ack data-memory handshake and loads the MEM/WB register.
// Optional feature: define ACCESS_TIMEOUT_EN to abandon accesses whose ack does not arrive within TIMEOUT_CYCLES.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regwBooleanIN,
  input  logic        memwBooleanIN,
  input  logic        MemrBooleanIN,
  input  logic [31:0] AIN,
  input  logic [31:0] ALUResultIN,
  input  logic [3:0]  regselectordestIN,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        regwBooleanWB,
  output logic        MemtoRegWB,
  output logic [31:0] ReadDataWB,
  output logic [31:0] ALUResultWB,
  output logic [3:0]  regselectordestWB,
  output logic        misalign_err,
  output logic        timeout_err
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        regw_q, regw_d;
  logic [3:0]  dest_q, dest_d;

  logic        wb_regw_q, wb_regw_d;
  logic        wb_m2r_q, wb_m2r_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [3:0]  wb_dest_q, wb_dest_d;
  logic        mis_q, mis_d;

  logic        stall_c;
  logic        mem_op;
  logic        aligned;

`ifdef ACCESS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  cnt_q, cnt_d;
  logic        to_q, to_d;
`else
  logic        cfg_unused;
  assign cfg_unused = |8'(TIMEOUT_CYCLES);
`endif

  assign mem_op  = memwBooleanIN | MemrBooleanIN;
  assign aligned = (ALUResultIN[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    regw_d     = regw_q;
    dest_d     = dest_q;
    wb_regw_d  = 1'b0;
    wb_m2r_d   = 1'b0;
    wb_rdata_d = wb_rdata_q;
    wb_alu_d   = wb_alu_q;
    wb_dest_d  = wb_dest_q;
    mis_d      = 1'b0;
    stall_c    = 1'b0;
`ifdef ACCESS_TIMEOUT_EN
    cnt_d      = cnt_q;
    to_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (mem_op && !aligned) begin
          mis_d = 1'b1;
        end else if (mem_op) begin
          addr_d  = ALUResultIN;
          wdata_d = AIN;
          we_d    = memwBooleanIN;
          regw_d  = regwBooleanIN;
          dest_d  = regselectordestIN;
          stall_c = 1'b1;
          state_d = ACCESS;
`ifdef ACCESS_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end else begin
          wb_regw_d = regwBooleanIN;
          wb_alu_d  = ALUResultIN;
          wb_dest_d = regselectordestIN;
        end
      end
      ACCESS: begin
        stall_c = !mem_ack;
        if (mem_ack) begin
          state_d   = IDLE;
          wb_regw_d = we_q ? 1'b0 : regw_q;
          wb_m2r_d  = !we_q;
          wb_alu_d  = addr_q;
          wb_dest_d = dest_q;
          if (!we_q) wb_rdata_d = mem_rdata;
        end
`ifdef ACCESS_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          // Release the EX register in the expiry cycle so the abandoned op is dropped, not retried.
          stall_c = 1'b0;
          state_d = IDLE;
          to_d    = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      regw_q     <= 1'b0;
      dest_q     <= '0;
      wb_regw_q  <= 1'b0;
      wb_m2r_q   <= 1'b0;
      wb_rdata_q <= '0;
      wb_alu_q   <= '0;
      wb_dest_q  <= '0;
      mis_q      <= 1'b0;
`ifdef ACCESS_TIMEOUT_EN
      cnt_q      <= '0;
      to_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      regw_q     <= regw_d;
      dest_q     <= dest_d;
      wb_regw_q  <= wb_regw_d;
      wb_m2r_q   <= wb_m2r_d;
      wb_rdata_q <= wb_rdata_d;
      wb_alu_q   <= wb_alu_d;
      wb_dest_q  <= wb_dest_d;
      mis_q      <= mis_d;
`ifdef ACCESS_TIMEOUT_EN
      cnt_q      <= cnt_d;
      to_q       <= to_d;
`endif
    end
  end

  // Stall is combinational from EX inputs, so reset must mask it directly.
  assign stall             = reset & stall_c;
  assign mem_req           = (state_q == ACCESS);
  assign mem_we            = we_q;
  assign mem_addr          = addr_q;
  assign mem_wdata         = wdata_q;
  assign regwBooleanWB     = wb_regw_q;
  assign MemtoRegWB        = wb_m2r_q;
  assign ReadDataWB        = wb_rdata_q;
  assign ALUResultWB       = wb_alu_q;
  assign regselectordestWB = wb_dest_q;
  assign misalign_err      = mis_q;
`ifdef ACCESS_TIMEOUT_EN
  assign timeout_err       = to_q;
`else
  assign timeout_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected write-backs are queued at drive time and popped by a WB monitor.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        regwBooleanIN, memwBooleanIN, MemrBooleanIN;
  logic [31:0] AIN, ALUResultIN, mem_rdata;
  logic [3:0]  regselectordestIN;
  logic        mem_ack;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        regwBooleanWB, MemtoRegWB;
  logic [31:0] ReadDataWB, ALUResultWB;
  logic [3:0]  regselectordestWB;
  logic        misalign_err, timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        regw;
    logic        m2r;
    logic [31:0] data;
    logic [3:0]  dest;
  } exp_t;
  exp_t sb[$];

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .regwBooleanIN(regwBooleanIN), .memwBooleanIN(memwBooleanIN), .MemrBooleanIN(MemrBooleanIN),
    .AIN(AIN), .ALUResultIN(ALUResultIN), .regselectordestIN(regselectordestIN),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .regwBooleanWB(regwBooleanWB), .MemtoRegWB(MemtoRegWB), .ReadDataWB(ReadDataWB),
    .ALUResultWB(ALUResultWB), .regselectordestWB(regselectordestWB),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // WB monitor: every visible write-back must match the head of the scoreboard.
  always @(negedge clk) begin : wb_monitor
    exp_t        e;
    logic [31:0] got;
    if (reset && (regwBooleanWB || MemtoRegWB)) begin
      checks++;
      got = MemtoRegWB ? ReadDataWB : ALUResultWB;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got regw=%0b m2r=%0b data=%h dest=%0d, required no write-back",
                 regwBooleanWB, MemtoRegWB, got, regselectordestWB);
      end else begin
        e = sb.pop_front();
        if (regwBooleanWB !== e.regw || MemtoRegWB !== e.m2r || got !== e.data || regselectordestWB !== e.dest) begin
          errors++;
          $display("FAIL wb_data: got regw=%0b m2r=%0b data=%h dest=%0d, required regw=%0b m2r=%0b data=%h dest=%0d",
                   regwBooleanWB, MemtoRegWB, got, regselectordestWB, e.regw, e.m2r, e.data, e.dest);
        end
      end
    end
  end

  task automatic set_ex(input logic rw, input logic mw, input logic mr,
                        input logic [31:0] a, input logic [31:0] alu, input logic [3:0] d);
    regwBooleanIN     = rw;
    memwBooleanIN     = mw;
    MemrBooleanIN     = mr;
    AIN               = a;
    ALUResultIN       = alu;
    regselectordestIN = d;
  endtask

  task automatic nop();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic test_reset();
    mem_ack = 1'b1;
    mem_rdata = 32'h1111_2222;
    set_ex(1'b1, 1'b0, 1'b1, 32'h5, 32'h100, 4'd7);
    #1;
    checks++;
    if ({stall, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem: got stall=%0b req=%0b we=%0b addr=%h wdata=%h, required all 0",
               stall, mem_req, mem_we, mem_addr, mem_wdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({regwBooleanWB, MemtoRegWB, ReadDataWB, ALUResultWB, regselectordestWB} !== '0) begin
      errors++;
      $display("FAIL reset_wb: got regw=%0b m2r=%0b rd=%h alu=%h dest=%0d, required all 0",
               regwBooleanWB, MemtoRegWB, ReadDataWB, ALUResultWB, regselectordestWB);
    end
    checks++;
    if ({stall, mem_req, misalign_err, timeout_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl: got stall=%0b req=%0b mis=%0b to=%0b, required 0",
               stall, mem_req, misalign_err, timeout_err);
    end
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    nop();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_alu();
    @(posedge clk); #1;
    set_ex(1'b1, 1'b0, 1'b0, 32'h0, 32'h1234, 4'd5);
    sb.push_back(exp_t'{1'b1, 1'b0, 32'h1234, 4'd5});
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL alu_stall: got stall=%0b req=%0b, required 0", stall, mem_req);
    end
    @(posedge clk); #1;
    nop();
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || MemtoRegWB !== 1'b0) begin
      errors++;
      $display("FAIL alu_wb_ctl: got stall=%0b m2r=%0b, required 0", stall, MemtoRegWB);
    end
  endtask

  task automatic test_load();
    int stall_cnt = 0;
    int bad = 0;
    @(posedge clk); #1;
    set_ex(1'b1, 1'b0, 1'b1, 32'h0, 32'h100, 4'd7);
    sb.push_back(exp_t'{1'b1, 1'b1, 32'hDEADBEEF, 4'd7});
    @(negedge clk);
    if (stall) stall_cnt++;
    checks++;
    if (stall !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL load_issue: got stall=%0b req=%0b, required stall=1 req=0", stall, mem_req);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
      end
      @(negedge clk);
      if (stall) stall_cnt++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL load_req: got %0d bad ACCESS cycles, required 0 (req=%0b we=%0b addr=%h)",
               bad, mem_req, mem_we, mem_addr);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    nop();
    @(negedge clk);
    checks++;
    if (stall_cnt != 4 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL load_stall: got stall cycles=%0d req=%0b, required 4 and req=0", stall_cnt, mem_req);
    end
  endtask

  task automatic test_store();
    int bad = 0;
    @(posedge clk); #1;
    set_ex(1'b1, 1'b1, 1'b0, 32'hCAFE0001, 32'h200, 4'd9);
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL store_issue: got stall=%0b, required 1", stall);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      AIN = 32'h0BAD_0000 + 32'(i);
      if (i == 2) mem_ack = 1'b1;
      @(negedge clk);
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hCAFE0001) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL store_req: got %0d bad ACCESS cycles, required 0 (we=%0b addr=%h wdata=%h)",
               bad, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    nop();
    @(negedge clk);
    checks++;
    if (regwBooleanWB !== 1'b0 || MemtoRegWB !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL store_wb: got regw=%0b m2r=%0b req=%0b, required 0", regwBooleanWB, MemtoRegWB, mem_req);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] addrs[2];
    addrs[0] = 32'h102;
    addrs[1] = 32'h201;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      set_ex(1'b1, k == 1, k == 0, 32'h77, addrs[k], 4'd3);
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || misalign_err !== 1'b0) begin
        errors++;
        $display("FAIL mis_issue: got stall=%0b req=%0b mis=%0b, required 0", stall, mem_req, misalign_err);
      end
      @(posedge clk); #1;
      nop();
      @(negedge clk);
      checks++;
      if (misalign_err !== 1'b1 || mem_req !== 1'b0 || regwBooleanWB !== 1'b0 || MemtoRegWB !== 1'b0) begin
        errors++;
        $display("FAIL mis_pulse: got mis=%0b req=%0b regw=%0b m2r=%0b, required mis=1 others 0",
                 misalign_err, mem_req, regwBooleanWB, MemtoRegWB);
      end
      @(negedge clk);
      checks++;
      if (misalign_err !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL mis_width: got mis=%0b req=%0b, required 0", misalign_err, mem_req);
      end
    end
  endtask

  task automatic test_ack_ignored();
    @(posedge clk); #1;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    set_ex(1'b1, 1'b0, 1'b0, 32'h0, 32'hA5A5_0000, 4'd2);
    sb.push_back(exp_t'{1'b1, 1'b0, 32'hA5A5_0000, 4'd2});
    @(posedge clk); #1;
    mem_ack = 1'b0;
    nop();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || MemtoRegWB !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle: got req=%0b m2r=%0b stall=%0b, required 0", mem_req, MemtoRegWB, stall);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [3:0]  d;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      v = $urandom & 32'hFFFF_FFFC;
      d = 4'($urandom_range(0, 15));
      set_ex(1'b1, 1'b0, 1'b0, 32'h0, v, d);
      sb.push_back(exp_t'{1'b1, 1'b0, v, d});
    end
    @(posedge clk); #1;
    set_ex(1'b1, 1'b0, 1'b1, 32'h0, 32'h40, 4'd3);
    sb.push_back(exp_t'{1'b1, 1'b1, 32'h1357_9BDF, 4'd3});
    @(posedge clk); #1;
    mem_ack = 1'b1;
    mem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack: got stall=%0b req=%0b, required stall=0 req=1", stall, mem_req);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    set_ex(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_BEE0, 4'd12);
    sb.push_back(exp_t'{1'b1, 1'b0, 32'h0000_BEE0, 4'd12});
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_follow: got stall=%0b req=%0b, required 0", stall, mem_req);
    end
    @(posedge clk); #1;
    nop();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    set_ex(1'b1, 1'b0, 1'b1, 32'h0, 32'h300, 4'd4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({stall, mem_req, mem_we, mem_addr, mem_wdata, regwBooleanWB, MemtoRegWB, ReadDataWB,
         ALUResultWB, regselectordestWB, misalign_err, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got stall=%0b req=%0b addr=%h regw=%0b m2r=%0b rd=%h alu=%h dest=%0d, required all 0",
               stall, mem_req, mem_addr, regwBooleanWB, MemtoRegWB, ReadDataWB, ALUResultWB, regselectordestWB);
    end
    nop();
    @(posedge clk); #1;
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h4444_4444;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || regwBooleanWB !== 1'b0 || MemtoRegWB !== 1'b0) begin
      errors++;
      $display("FAIL reset_abandon: got req=%0b regw=%0b m2r=%0b, required 0", mem_req, regwBooleanWB, MemtoRegWB);
    end
  endtask

  task automatic test_long_wait();
    int n = 0;
    int bad = 0;
    @(posedge clk); #1;
    set_ex(1'b1, 1'b0, 1'b1, 32'h0, 32'h500, 4'd6);
    @(negedge clk);
`ifdef ACCESS_TIMEOUT_EN
    begin : to_wait
      logic done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
        @(negedge clk);
        if (mem_req) n++;
        if (mem_req && stall === 1'b0) begin
          @(posedge clk); #1;
          nop();
          @(negedge clk);
          done = 1'b1;
        end
      end
      checks++;
      if (!done || timeout_err !== 1'b1 || mem_req !== 1'b0 || stall !== 1'b0 || regwBooleanWB !== 1'b0) begin
        errors++;
        $display("FAIL timeout: got done=%0b to=%0b req=%0b stall=%0b regw=%0b, required done=1 to=1 others 0",
                 done, timeout_err, mem_req, stall, regwBooleanWB);
      end
      checks++;
      if (n != 255) begin
        errors++;
        $display("FAIL timeout_len: got %0d request cycles, required 255", n);
      end
      @(negedge clk);
      checks++;
      if (timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_width: got to=%0b, required 0", timeout_err);
      end
    end
`else
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (mem_req !== 1'b1 || stall !== 1'b1 || timeout_err !== 1'b0 || mem_addr !== 32'h500) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wait_hold: got %0d bad cycles of %0d, required 0", bad, n);
    end
    sb.push_back(exp_t'{1'b1, 1'b1, 32'h2468_ACE0, 4'd6});
    @(posedge clk); #1;
    mem_ack = 1'b1;
    mem_rdata = 32'h2468_ACE0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    nop();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL wait_done: got req=%0b to=%0b, required 0", mem_req, timeout_err);
    end
`endif
  endtask

  initial begin
    nop();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misalign();
    test_ack_ignored();
    test_back_to_back();
    test_reset_mid_access();
    test_long_wait();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending write-backs, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
